rr_grant_sequencer: RTL and testbench
=====================================

# rr_grant_sequencer

Four-channel round-robin grant sequencer that sits directly upstream of the 2-to-4 structural decoder. It arbitrates among four request lines and drives the decoder's select pair and enable, so the decoder output is a one-hot grant. Each grant is held until the owner releases it, drops its request, or a hold-time limit expires. Fairness comes from a rotating priority pointer.

## Interface
Parameters:
- HOLD_MAX, default 8: maximum consecutive cycles one grant may be held. Legal range is 1..255. The hold counter is 8 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  4  request lines; req[i] asks for channel i.
- done  input  1  release strobe from the current grant owner.
- A  output  1  select MSB to the decoder (grant index bit 1).
- B  output  1  select LSB to the decoder (grant index bit 0).
- enable  output  1  decoder enable; high only while a grant is active.
- busy  output  1  high while in GRANT state; identical to enable.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

## Operation
- State machine has two states, IDLE and GRANT. Reset enters IDLE.
- Reset values:
  - A=0, B=0, enable=0, busy=0, timeout=0.
  - Hold counter = 0.
  - Last-grant pointer `last` = 3, so channel 0 has top priority after reset.
- IDLE:
  - If req is nonzero, choose the first asserted channel in order last+1, last+2, last+3, last (all mod 4). The previous owner is therefore lowest priority.
  - Register the chosen index onto {A,B}, set enable=1, load hold counter = 1, and go to GRANT.
  - If req is zero, stay in IDLE. {A,B} keeps its last value and enable=0.
- GRANT: release is evaluated every cycle with this priority:
  1. done=1 releases the grant.
  2. Otherwise, req[owner]=0 releases the grant.
  3. Otherwise, counter == HOLD_MAX releases the grant and asserts timeout for one cycle.
  4. Otherwise, the counter increments and the grant holds.
- On release: enable goes to 0, `last` is set to the owner, and the state returns to IDLE. {A,B} holds its value.
- {A,B} never changes while enable=1. The decoder therefore sees glitch-free selects with the enable gating its output.
- Requests from other channels during GRANT are ignored until the next IDLE evaluation. There is no preemption.
- If done and the timeout condition occur in the same cycle, timeout stays 0 (done wins).
- Asserting rst_n low mid-grant forces enable=0 and the IDLE state immediately (asynchronously) and restores `last`=3.

## Timing
- Grant latency: req sampled high at edge N in IDLE gives enable=1 with a valid {A,B} after edge N. The grant is visible during cycle N+1. All outputs are registered.
- Release latency: done or req-drop sampled at edge M gives enable=0 after edge M.
- Mandatory gap: there is always at least one cycle with enable=0 between consecutive grants, even when req stays high. The earliest next grant is visible after edge M+1.
- Maximum hold: with req held and no done, enable stays high for exactly HOLD_MAX cycles.
- Timeout pulse: timeout is high during the first enable=0 cycle after a timeout release.
- Throughput: when all four channels request continuously and HOLD_MAX=1, grants rotate 0,1,2,3,0,… with one grant every 2 cycles.
- Wrap-around: the pointer moves from 3 to 0 modulo 4 with no special case.

## Test plan
- Reset then single request: rst_n low→high, req=4'b0100 at cycle 2. Expect A=1, B=0, enable=1 from cycle 3, and the decoder Y2=1. Pulse done at cycle 5; expect enable=0 from cycle 6.
- Round-robin fairness: HOLD_MAX=8, req=4'b1111 held, done pulsed on the second cycle of each grant. Expect grant sequence 0,1,2,3,0 with a one-cycle gap between each grant.
- Timeout: HOLD_MAX=3, req=4'b0010 held, no done. Expect enable high for exactly 3 cycles with {A,B}=01, then one timeout pulse in the gap cycle, then a re-grant to channel 1 (the only requester).
- Request drop and simultaneous events: owner 2 drops req[2] while done=1 on the cycle the counter reaches HOLD_MAX. Expect release with timeout=0.
- Reset mid-grant: channel 3 granted, rst_n pulsed low for half a cycle. Expect enable=0 immediately (asynchronously). With req=4'b1001 afterwards, expect channel 0 to win first.
- Idle stability: req=0 for 20 cycles after a grant to channel 2. Expect enable=0, timeout=0, and {A,B} held at 10 throughout.

Source files
------------

// File: rtl/rr_grant_sequencer.sv
// rtl/rr_grant_sequencer.sv - four-channel round-robin grant sequencer driving a 2-to-4 decoder
module rr_grant_sequencer #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       A,
  output logic       B,
  output logic       enable,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;
  logic [1:0] w_pick;
  logic [1:0] w_cand;
  logic       w_pick_valid;

  // Scan from farthest to nearest so the channel right after the last owner wins.
  always_comb begin
    w_pick       = r_last;
    w_cand       = r_last;
    w_pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_last + 2'(k);
      if (req[w_cand]) begin
        w_pick       = w_cand;
        w_pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done || !req[r_sel]) begin
          w_last_nxt  = r_sel;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == HOLD_LIMIT) begin
          w_last_nxt    = r_sel;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'd0;
      r_last    <= 2'd3;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign A       = r_sel[1];
  assign B       = r_sel[0];
  assign enable  = (r_state == S_GRANT);
  assign busy    = (r_state == S_GRANT);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// tb/tb_rr_grant_sequencer.sv - directed self-checking bench for rr_grant_sequencer
module tb_rr_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;

  logic a8, b8, en8, busy8, to8;
  logic a3, b3, en3, busy3, to3;
  logic a1, b1, en1, busy1, to1;

  int n_checks;
  int n_fail;

  rr_grant_sequencer #(.HOLD_MAX(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a8), .B(b8), .enable(en8), .busy(busy8), .timeout(to8)
  );

  rr_grant_sequencer #(.HOLD_MAX(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a3), .B(b3), .enable(en3), .busy(busy3), .timeout(to3)
  );

  rr_grant_sequencer #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a1), .B(b1), .enable(en1), .busy(busy1), .timeout(to1)
  );

  // Decoder model: one-hot output gated by enable.
  logic [3:0] y8;
  assign y8 = en8 ? (4'b0001 << {a8, b8}) : 4'b0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    n_checks = 0;
    n_fail   = 0;

    // Reset state and single request to channel 2
    do_reset();
    check_eq("rst_en",   32'(en8),        0);
    check_eq("rst_busy", 32'(busy8),      0);
    check_eq("rst_ab",   32'({a8, b8}),   0);
    check_eq("rst_to",   32'(to8),        0);
    tick();
    req = 4'b0100;
    tick();
    check_eq("single_en",   32'(en8),      1);
    check_eq("single_busy", 32'(busy8),    1);
    check_eq("single_ab",   32'({a8, b8}), 2);
    check_eq("single_y",    32'(y8),       32'h4);
    tick();
    check_eq("single_hold", 32'(en8), 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    check_eq("single_rel_en", 32'(en8), 0);
    check_eq("single_rel_to", 32'(to8), 0);
    check_eq("single_rel_ab", 32'({a8, b8}), 2);

    // Idle stability after grant to channel 2
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_en", 32'(en8), 0);
      check_eq("idle_to", 32'(to8), 0);
      check_eq("idle_ab", 32'({a8, b8}), 2);
    end

    // Round-robin fairness with done on the second grant cycle
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_en",  32'(en8), 1);
      check_eq("rr_idx", 32'({a8, b8}), 32'(k % 4));
      tick();
      check_eq("rr_hold", 32'(en8), 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_eq("rr_gap", 32'(en8), 0);
      check_eq("rr_gap_to", 32'(to8), 0);
      tick();
    end

    // Timeout with HOLD_MAX=3 and a lone requester
    do_reset();
    req = 4'b0010;
    tick();
    cycles = 0;
    while (en3 && cycles < 20) begin
      check_eq("to_ab", 32'({a3, b3}), 1);
      check_eq("to_no_pulse", 32'(to3), 0);
      cycles++;
      tick();
    end
    check_eq("to_hold_len", 32'(cycles), 3);
    check_eq("to_gap_en",   32'(en3), 0);
    check_eq("to_pulse",    32'(to3), 1);
    tick();
    check_eq("to_regrant_en", 32'(en3), 1);
    check_eq("to_regrant_ab", 32'({a3, b3}), 1);
    check_eq("to_pulse_end",  32'(to3), 0);

    // Request drop plus done on the cycle the counter hits HOLD_MAX
    do_reset();
    req = 4'b0100;
    tick();
    check_eq("sim_grant", 32'({a3, b3}), 2);
    tick();
    tick();
    check_eq("sim_still", 32'(en3), 1);
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    check_eq("sim_rel_en", 32'(en3), 0);
    check_eq("sim_rel_to", 32'(to3), 0);

    // Done alone at the limit also suppresses timeout
    req = 4'b0100;
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    check_eq("done_lim_en", 32'(en3), 0);
    check_eq("done_lim_to", 32'(to3), 0);

    // Asynchronous reset mid-grant
    do_reset();
    req = 4'b1000;
    tick();
    check_eq("mid_grant_ab", 32'({a8, b8}), 3);
    check_eq("mid_grant_en", 32'(en8), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_en",   32'(en8),   0);
    check_eq("async_busy", 32'(busy8), 0);
    #4;
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    check_eq("post_rst_en", 32'(en8), 1);
    check_eq("post_rst_ab", 32'({a8, b8}), 0);
    req = 4'b0000;
    tick();

    // Throughput with HOLD_MAX=1: rotation 0,1,2,3,0 every two cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("tp_en",  32'(en1), 1);
      check_eq("tp_idx", 32'({a1, b1}), 32'(k % 4));
      tick();
      check_eq("tp_gap", 32'(en1), 0);
      check_eq("tp_to",  32'(to1), 1);
    end
    req = 4'b0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
